adder_tree_loader: RTL and testbench
====================================

ADDER_TREE_LOADER -- requirements
Module: adder_tree_loader

Interface
REQ-001 Parameter ADDER_WIDTH, default 11, SHALL set the width of each operand word.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port in_data  input  ADDER_WIDTH  SHALL carry the operand word offered by the upstream source.
REQ-005 Port in_valid  input  1  SHALL indicate in_data is valid.
REQ-006 Port in_last  input  1  SHALL mark the offered word as the final word of a short group; qualified by in_valid.
REQ-007 Port in_ready  output  1  SHALL indicate the loader accepts a word this cycle.
REQ-008 Ports op0..op7  output  ADDER_WIDTH each  SHALL present the eight collected operands; op0..op7 map in order to adder tree inputs isum0_0_0_0, isum0_0_0_1, isum0_0_1_0, isum0_0_1_1, isum0_1_0_0, isum0_1_0_1, isum0_1_1_0, isum0_1_1_1.
REQ-009 Port out_valid  output  1  SHALL indicate op0..op7 and out_count form a complete group.
REQ-010 Port out_ready  input  1  SHALL indicate the downstream adder tree consumes the group this cycle.
REQ-011 Port out_count  output  4  SHALL give the number of real (non-padded) operands in the group, 1..8.

Function
REQ-012 The block SHALL have two states: FILL (collecting) and HOLD (group presented).
REQ-013 in_ready SHALL equal 1 in FILL and 0 in HOLD, and 0 while rst is asserted.
REQ-014 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1; no other cycle alters any slot from input.
REQ-015 A 3-bit write index SHALL select the slot; slot k drives op<k>; index increments by 1 per accepted word.
REQ-016 Accepting a word at index 7 SHALL store it, set out_count to 8, and enter HOLD on the same edge.
REQ-017 Accepting a word with in_last=1 at index i<7 SHALL store it in slot i, write zero to slots i+1..7 on the same edge, set out_count to i+1, and enter HOLD.
REQ-018 in_last=1 at index 7 SHALL behave identically to REQ-016.
REQ-019 out_valid SHALL be 1 exactly while in HOLD; it asserts the cycle after the completing word is accepted (latency 1 cycle from final accept).
REQ-020 In HOLD, op0..op7 and out_count SHALL remain stable until handoff.
REQ-021 In HOLD with out_ready=1 on a rising edge, the block SHALL return to FILL with index 0; in_ready becomes 1 the following cycle (no same-cycle pass-through).
REQ-022 In HOLD with out_ready=0, the block SHALL stay in HOLD indefinitely; in_valid is ignored.
REQ-023 out_ready in FILL SHALL have no effect.
REQ-024 In FILL, op0..op7 SHALL show current slot contents (partial group); consumers use them only when out_valid=1.
REQ-025 Slot contents SHALL be written unsigned, without extension or modification; zero padding is the only value the block generates.
REQ-026 Back-to-back groups SHALL sustain one group per 9 cycles with continuous in_valid and out_ready=1.

Reset
REQ-027 On rst assertion, asynchronously: state SHALL be FILL, index 0, all slots 0, out_count 0, out_valid 0.
REQ-028 rst asserted mid-FILL or in HOLD SHALL discard the partial or pending group; no out_valid on release.
REQ-029 After rst deasserts, the first rising edge with in_valid=1 SHALL accept into slot 0.

Verification
REQ-030 Full group: words 1..8 on consecutive cycles, out_ready=1 -> out_valid for one cycle, op0..op7 = 1..8, out_count=8, then in_ready=1.
REQ-031 Short group: words 0x7FF, 0x001, 0x155 with in_last on third -> op0=0x7FF, op1=0x001, op2=0x155, op3..op7=0, out_count=3.
REQ-032 Backpressure: complete group, hold out_ready=0 for 5 cycles while in_valid=1 with new data -> outputs stable, in_ready=0, no word lost or written; release -> next group starts at slot 0 with the next offered word.
REQ-033 Single word: in_last with first word 0x2A -> op0=0x2A, others 0, out_count=1.
REQ-034 Reset mid-operation: accept 5 words, assert rst asynchronously between edges -> out_valid=0, all op=0, out_count=0 immediately; after release, new 8-word group loads from slot 0 correctly.
REQ-035 Gapped input: 8 words with random in_valid gaps -> same result as REQ-030; slots unchanged on idle cycles.

Source files
------------

// File: rtl/adder_tree_loader.sv
// Adder tree operand loader.
// Collects up to eight operand words into slots 0..7, zero-pads short groups,
// and presents the complete group plus its real-operand count to the tree.
module adder_tree_loader #(
    parameter int ADDER_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDER_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [ADDER_WIDTH-1:0] op0,
    output logic [ADDER_WIDTH-1:0] op1,
    output logic [ADDER_WIDTH-1:0] op2,
    output logic [ADDER_WIDTH-1:0] op3,
    output logic [ADDER_WIDTH-1:0] op4,
    output logic [ADDER_WIDTH-1:0] op5,
    output logic [ADDER_WIDTH-1:0] op6,
    output logic [ADDER_WIDTH-1:0] op7,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_count
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_idx;
    logic [3:0]             r_count;
    logic [ADDER_WIDTH-1:0] r_slot [0:7];

    logic w_accept;
    logic w_complete;

    // The ready term is gated by rst so the source never sees ready during reset.
    assign in_ready   = ~rst & (r_state == ST_FILL);
    assign w_accept   = in_valid & in_ready;
    assign w_complete = w_accept & (in_last | (r_idx == 3'd7));

    // Group-level control: write index, operand count and FILL/HOLD sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_idx   <= 3'd0;
            r_count <= 4'd0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_complete) begin
                        r_count <= {1'b0, r_idx} + 4'd1;
                        r_idx   <= 3'd0;
                        r_state <= ST_HOLD;
                    end else if (w_accept) begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                ST_HOLD: begin
                    // Handoff: the next group starts at slot 0 one cycle later.
                    if (out_ready) begin
                        r_state <= ST_FILL;
                        r_count <= 4'd0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                    r_idx   <= 3'd0;
                    r_count <= 4'd0;
                end
            endcase
        end
    end

    // One register per slot: load on an accept aimed at this slot, or clear when
    // a short group finishes below it. Slots are untouched in every other cycle.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            localparam logic [2:0] SLOT_IDX = 3'(gi);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_slot[gi] <= '0;
                end else if (w_accept && (r_idx == SLOT_IDX)) begin
                    r_slot[gi] <= in_data;
                end else if (w_complete && (SLOT_IDX > r_idx)) begin
                    r_slot[gi] <= '0;
                end
            end
        end
    endgenerate

    assign op0       = r_slot[0];
    assign op1       = r_slot[1];
    assign op2       = r_slot[2];
    assign op3       = r_slot[3];
    assign op4       = r_slot[4];
    assign op5       = r_slot[5];
    assign op6       = r_slot[6];
    assign op7       = r_slot[7];
    assign out_valid = (r_state == ST_HOLD);
    assign out_count = r_count;

endmodule

// File: tb/tb_adder_tree_loader.sv
// Self-checking bench for adder_tree_loader: table-driven groups, hand-written
// corner sequences and a randomized run against a group-level reference model.
module tb_adder_tree_loader;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] op0, op1, op2, op3, op4, op5, op6, op7;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_count;

    logic [W-1:0] w_op [8];
    assign w_op[0] = op0;
    assign w_op[1] = op1;
    assign w_op[2] = op2;
    assign w_op[3] = op3;
    assign w_op[4] = op4;
    assign w_op[5] = op5;
    assign w_op[6] = op6;
    assign w_op[7] = op7;

    adder_tree_loader #(.ADDER_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .op0       (op0),
        .op1       (op1),
        .op2       (op2),
        .op3       (op3),
        .op4       (op4),
        .op5       (op5),
        .op6       (op6),
        .op7       (op7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a list of words gathered for the current group, the
    // visible slot image, and whether a finished group is waiting for handoff.
    logic [W-1:0] m_slot [8];
    logic [W-1:0] m_group [$];
    bit           m_hold;
    int           m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_slot[k] = '0;
        m_group.delete();
        m_hold = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic v, input logic l, input logic [W-1:0] d, input logic o);
        if (!m_hold) begin
            if (v) begin
                m_group.push_back(d);
                m_slot[m_group.size() - 1] = d;
                if (l || m_group.size() == 8) begin
                    for (int k = m_group.size(); k < 8; k++) m_slot[k] = '0;
                    m_cnt  = m_group.size();
                    m_hold = 1'b1;
                    $display("group complete: count=%0d first=0x%0h at %0t", m_cnt, m_group[0], $time);
                    m_group.delete();
                end
            end
        end else if (o) begin
            m_hold = 1'b0;
        end
    endtask

    task automatic check_all();
        check("in_ready", in_ready, !m_hold);
        check("out_valid", out_valid, m_hold);
        for (int k = 0; k < 8; k++) check($sformatf("op%0d", k), w_op[k], m_slot[k]);
        if (m_hold) check("out_count", out_count, m_cnt);
    endtask

    // Advance one clock: capture the inputs offered before the edge, step the
    // model with them, and compare all outputs shortly after the edge.
    task automatic tick();
        logic v, l, o;
        logic [W-1:0] d;
        v = in_valid; l = in_last; o = out_ready; d = in_data;
        @(posedge clk);
        #1;
        if (!rst) begin
            model_step(v, l, d, o);
            check_all();
        end
    endtask

    typedef struct packed {
        logic [3:0]        n;
        logic              use_last;
        logic [7:0][W-1:0] w;
        logic [7:0][W-1:0] exp_op;
        logic [3:0]        exp_cnt;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v, input int id);
        out_ready = 1'b1;
        for (int k = 0; k < int'(v.n); k++) begin
            in_valid = 1'b1;
            in_data  = v.w[k];
            in_last  = v.use_last && (k == int'(v.n) - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 11'h3C3;
        check($sformatf("vec%0d out_valid", id), out_valid, 1'b1);
        check($sformatf("vec%0d out_count", id), out_count, v.exp_cnt);
        for (int k = 0; k < 8; k++) check($sformatf("vec%0d op%0d", id, k), w_op[k], v.exp_op[k]);
        tick();
        check($sformatf("vec%0d out_valid drop", id), out_valid, 1'b0);
        check($sformatf("vec%0d in_ready back", id), in_ready, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " out_valid"}, out_valid, 1'b0);
        check({tag, " in_ready"}, in_ready, 1'b0);
        check({tag, " out_count"}, out_count, 4'd0);
        for (int k = 0; k < 8; k++) check($sformatf("%s op%0d", tag, k), w_op[k], '0);
    endtask

    initial begin
        logic [W-1:0] bp_next;
        logic [W-1:0] hold_img [8];
        int t_prev, gaps;

        // Table: full group, short group, single word, last on 8th, last on 7th.
        for (int i = 0; i < 5; i++) vecs[i] = '0;
        vecs[0].n = 4'd8; vecs[0].use_last = 1'b0; vecs[0].exp_cnt = 4'd8;
        for (int k = 0; k < 8; k++) begin
            vecs[0].w[k]      = W'(k + 1);
            vecs[0].exp_op[k] = W'(k + 1);
        end
        vecs[1].n = 4'd3; vecs[1].use_last = 1'b1; vecs[1].exp_cnt = 4'd3;
        vecs[1].w[0] = 11'h7FF; vecs[1].w[1] = 11'h001; vecs[1].w[2] = 11'h155;
        vecs[1].exp_op[0] = 11'h7FF; vecs[1].exp_op[1] = 11'h001; vecs[1].exp_op[2] = 11'h155;
        vecs[2].n = 4'd1; vecs[2].use_last = 1'b1; vecs[2].exp_cnt = 4'd1;
        vecs[2].w[0] = 11'h02A; vecs[2].exp_op[0] = 11'h02A;
        vecs[3].n = 4'd8; vecs[3].use_last = 1'b1; vecs[3].exp_cnt = 4'd8;
        for (int k = 0; k < 8; k++) begin
            vecs[3].w[k]      = W'(11'h400 + k);
            vecs[3].exp_op[k] = W'(11'h400 + k);
        end
        vecs[4].n = 4'd7; vecs[4].use_last = 1'b1; vecs[4].exp_cnt = 4'd7;
        for (int k = 0; k < 7; k++) begin
            vecs[4].w[k]      = W'(11'h7F0 - k);
            vecs[4].exp_op[k] = W'(11'h7F0 - k);
        end

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready after release", in_ready, 1'b1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Backpressure: complete a group, stall 5 cycles with new data offered.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_last = 1'b0; in_data = W'($urandom); tick();
        end
        for (int k = 0; k < 8; k++) hold_img[k] = m_slot[k];
        for (int c = 0; c < 5; c++) begin
            in_data = W'($urandom); in_last = c[0]; tick();
            check("bp in_ready low", in_ready, 1'b0);
            for (int k = 0; k < 8; k++) check($sformatf("bp stable op%0d", k), w_op[k], hold_img[k]);
        end
        out_ready = 1'b1; in_last = 1'b0; in_data = 11'h111;
        tick();
        check("bp released", out_valid, 1'b0);
        bp_next = 11'h2B7;
        in_data = bp_next;
        tick();
        check("bp next word slot0", op0, bp_next);
        for (int k = 1; k < 8; k++) begin
            in_data = W'($urandom); tick();
        end
        in_valid = 1'b0; tick();

        // Throughput: continuous traffic must deliver one group every 9 cycles.
        in_valid = 1'b1; out_ready = 1'b1; in_last = 1'b0;
        t_prev = -1; gaps = 0;
        for (int c = 0; c < 40; c++) begin
            in_data = W'($urandom);
            tick();
            if (out_valid) begin
                if (t_prev >= 0) begin
                    check("throughput period", c - t_prev, 9);
                    gaps++;
                end
                t_prev = c;
            end
        end
        check("throughput groups seen", gaps >= 3, 1'b1);
        in_valid = 1'b0;
        while (m_hold || m_group.size() != 0) begin
            in_valid = !m_hold; in_data = W'($urandom); in_last = 1'b1; tick();
        end
        in_valid = 1'b0; in_last = 1'b0;

        // Reset mid-FILL, asserted between edges.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = W'(11'h500 + k); tick();
        end
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1 check_reset_outputs("rst mid fill");
        model_reset();
        @(negedge clk); rst = 1'b0;
        #1 check("mid fill no out_valid", out_valid, 1'b0);
        run_vec(vecs[0], 10);

        // Reset while a group is pending in HOLD.
        out_ready = 1'b0;
        run_vec(vecs[2], 11);
        in_valid = 1'b1; in_last = 1'b1; in_data = 11'h0AA; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("pending before rst", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst in hold");
        model_reset();
        @(negedge clk); rst = 1'b0;
        #1 check("hold no out_valid", out_valid, 1'b0);

        // Gapped input: words 1..8 with random idle cycles.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0; in_last = 1'b1; in_data = W'($urandom); tick();
            end
            in_valid = 1'b1; in_last = 1'b0; in_data = W'(k + 1); tick();
        end
        in_valid = 1'b0;
        check("gapped out_valid", out_valid, 1'b1);
        check("gapped out_count", out_count, 4'd8);
        for (int k = 0; k < 8; k++) check($sformatf("gapped op%0d", k), w_op[k], W'(k + 1));
        tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 5) == 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
